ysyx_25030081_alu_arbiter: RTL and testbench

- Shares the single integer ALU (ysyx_25030081_alu) between two requesters: port 0 = EXU, port 1 = branch/AGU path.
- Accepts ALU operations over per-requester valid/ready channels and arbitrates round-robin.
- Drives the shared ALU combinationally and registers its result into a one-entry response buffer.
- Returns the result to the originating requester over a per-requester response channel.

---
 rtl/ysyx_25030081_alu_pkg.sv | 36 +++
 rtl/ysyx_25030081_alu.sv | 59 +++++
 rtl/ysyx_25030081_alu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_ysyx_25030081_alu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030081_alu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25030081_alu_pkg
// Shared definitions for the integer ALU and its two-port arbiter:
//   - ALU opcode encodings
//   - 1-bit requester id type (REQ_EXU / REQ_AGU)
//   - response-buffer state encoding (EMPTY / FULL)
//   - id_onehot(): requester id -> 2-bit one-hot lane mask
// ----------------------------------------------------------------------------
package ysyx_25030081_alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_PASS2 = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;

  typedef logic req_id_t;
  localparam req_id_t REQ_EXU = 1'b0;
  localparam req_id_t REQ_AGU = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return (id == REQ_AGU) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ysyx_25030081_alu.sv
// ----------------------------------------------------------------------------
// ysyx_25030081_alu
// Purely combinational 32-bit integer ALU.
// Ports:
//   op   [3:0]  opcode (see ysyx_25030081_alu_pkg)
//   op1, op2    operands
//   ucmp        1: less flag uses unsigned compare, 0: signed compare
//   out         result
//   zero        out == 0
//   less        op1 < op2 (signedness chosen by ucmp)
// ----------------------------------------------------------------------------
module ysyx_25030081_alu
  import ysyx_25030081_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic                  ucmp,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  zero,
  output logic                  less
);

  logic signed [DATA_WIDTH-1:0] op1_s;
  logic signed [DATA_WIDTH-1:0] op2_s;
  logic [4:0]                   shamt;
  logic                         lt_s;
  logic                         lt_u;

  always_comb begin
    op1_s = op1;
    op2_s = op2;
    shamt = op2[4:0];
    lt_s  = (op1_s < op2_s);
    lt_u  = (op1 < op2);
    out   = '0;
    case (op)
      ALU_ADD:   out = op1 + op2;
      ALU_SUB:   out = op1 - op2;
      ALU_SLL:   out = op1 << shamt;
      ALU_SLT:   out = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU:  out = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      ALU_PASS2: out = op2;
      ALU_XOR:   out = op1 ^ op2;
      ALU_SRL:   out = op1 >> shamt;
      ALU_SRA:   out = op1_s >>> shamt;
      ALU_OR:    out = op1 | op2;
      ALU_AND:   out = op1 & op2;
      default:   out = '0;
    endcase
    // The less flag follows ucmp regardless of opcode, so SLTU's result and
    // the flag can disagree when ucmp=0.
    less = ucmp ? lt_u : lt_s;
    zero = (out == '0);
  end

endmodule

// File: rtl/ysyx_25030081_alu_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_25030081_alu_arbiter
// Shares one ysyx_25030081_alu between requester 0 (EXU) and requester 1
// (branch/AGU) with 2-way round-robin arbitration and a one-entry registered
// response buffer. One operation per cycle is sustained when the owner of
// the buffered result drains it in the same cycle a new op is accepted.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid[1:0]           per-requester operation valid
//   req_ready[1:0]           per-requester accept (at most one bit set)
//   reqN_op/op1/op2/ucmp     per-requester ALU operation
//   rsp_valid[1:0]           result valid for the owning requester
//   rsp_ready[1:0]           per-requester result consume
//   rsp_out/zero/less        registered result bus shared by both requesters
//
// Optional build macro YSYX_25030081_ALU_ARB_PERF_EN adds perf_grant0,
// perf_grant1 (accept counts) and perf_conflict (cycles with both valid).
// ----------------------------------------------------------------------------
module ysyx_25030081_alu_arbiter
  import ysyx_25030081_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int INIT_PRIO  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [3:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic                  req0_ucmp,
  input  logic [3:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic                  req1_ucmp,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_out,
  output logic                  rsp_zero,
  output logic                  rsp_less
`ifdef YSYX_25030081_ALU_ARB_PERF_EN
  ,
  output logic [31:0]           perf_grant0,
  output logic [31:0]           perf_grant1,
  output logic [31:0]           perf_conflict
`endif
);

  // The pointer holds the last winner, so it resets to the opposite of the
  // requester that should win the first conflict.
  localparam req_id_t LAST_RST = (INIT_PRIO == 0) ? REQ_AGU : REQ_EXU;

  buf_state_t            state_q, state_d;
  req_id_t               owner_q, owner_d;
  req_id_t               last_q,  last_d;
  logic [DATA_WIDTH-1:0] out_q,   out_d;
  logic                  zero_q,  zero_d;
  logic                  less_q,  less_d;

  req_id_t               gnt;
  logic                  can_accept;
  logic                  accept;
  logic                  drain;

  logic [3:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic                  alu_ucmp;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_zero;
  logic                  alu_less;

  ysyx_25030081_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .op   (alu_op),
    .op1  (alu_op1),
    .op2  (alu_op2),
    .ucmp (alu_ucmp),
    .out  (alu_out),
    .zero (alu_zero),
    .less (alu_less)
  );

  always_comb begin
    drain      = (state_q == ST_FULL) && rsp_ready[owner_q];
    // Gated by rst_n so nothing is acknowledged while reset is asserted.
    can_accept = rst_n && ((state_q == ST_EMPTY) || rsp_ready[owner_q]);

    if (&req_valid)        gnt = ~last_q;
    else if (req_valid[1]) gnt = REQ_AGU;
    else                   gnt = REQ_EXU;

    req_ready = can_accept ? (req_valid & id_onehot(gnt)) : 2'b00;
    accept    = |req_ready;

    // With no request gnt falls back to EXU, so the ALU sees requester 0.
    if (gnt == REQ_AGU) begin
      alu_op   = req1_op;
      alu_op1  = req1_op1;
      alu_op2  = req1_op2;
      alu_ucmp = req1_ucmp;
    end else begin
      alu_op   = req0_op;
      alu_op1  = req0_op1;
      alu_op2  = req0_op2;
      alu_ucmp = req0_ucmp;
    end

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    out_d   = out_q;
    zero_d  = zero_q;
    less_d  = less_q;
    if (accept) begin
      state_d = ST_FULL;
      owner_d = gnt;
      last_d  = gnt;
      out_d   = alu_out;
      zero_d  = alu_zero;
      less_d  = alu_less;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      owner_q <= REQ_EXU;
      last_q  <= LAST_RST;
      out_q   <= '0;
      zero_q  <= 1'b0;
      less_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      less_q  <= less_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL) ? id_onehot(owner_q) : 2'b00;
  assign rsp_out   = out_q;
  assign rsp_zero  = zero_q;
  assign rsp_less  = less_q;

`ifdef YSYX_25030081_ALU_ARB_PERF_EN
  logic [31:0] perf_grant0_q,   perf_grant0_d;
  logic [31:0] perf_grant1_q,   perf_grant1_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  always_comb begin
    perf_grant0_d   = perf_grant0_q   + {31'd0, req_ready[0]};
    perf_grant1_d   = perf_grant1_q   + {31'd0, req_ready[1]};
    perf_conflict_d = perf_conflict_q + {31'd0, &req_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0_q   <= '0;
      perf_grant1_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_grant0_q   <= perf_grant0_d;
      perf_grant1_q   <= perf_grant1_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_grant0   = perf_grant0_q;
  assign perf_grant1   = perf_grant1_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_ysyx_25030081_alu_arbiter.sv
module tb_ysyx_25030081_alu_arbiter;
  import ysyx_25030081_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic        req0_ucmp, req1_ucmp;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_out;
  logic        rsp_zero, rsp_less;
`ifdef YSYX_25030081_ALU_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state: the pending response (if any) and the last winner.
  bit          m_full;
  bit          m_owner;
  bit          m_last;
  logic [31:0] m_out;
  bit          m_zero, m_less;

  logic [3:0] ops [11] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_PASS2,
                           ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};

  ysyx_25030081_alu_arbiter #(.DATA_WIDTH(32), .INIT_PRIO(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_op   (req0_op),
    .req0_op1  (req0_op1),
    .req0_op2  (req0_op2),
    .req0_ucmp (req0_ucmp),
    .req1_op   (req1_op),
    .req1_op1  (req1_op1),
    .req1_op2  (req1_op2),
    .req1_ucmp (req1_ucmp),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero),
    .rsp_less  (rsp_less)
`ifdef YSYX_25030081_ALU_ARB_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arithmetic meaning of each opcode, written from the instruction semantics.
  function automatic logic [31:0] ref_out(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLL:   return a << sh;
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_PASS2: return b;
      ALU_XOR:   return a ^ b;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return $unsigned($signed(a) >>> sh);
      ALU_OR:    return a | b;
      ALU_AND:   return a & b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_full = 0; m_owner = 0; m_last = 1; m_out = '0; m_zero = 0; m_less = 0;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic u);
    if (i == 0) begin req0_op = op; req0_op1 = a; req0_op2 = b; req0_ucmp = u; end
    else        begin req1_op = op; req1_op1 = a; req1_op2 = b; req1_ucmp = u; end
  endtask

  // Called with inputs already driven just after a falling edge; checks the
  // DUT against the reference, advances one clock, and returns at the next
  // falling edge.
  task automatic step();
    bit          can, g;
    logic [1:0]  er, ev;
    logic [3:0]  op;
    logic [31:0] a, b;
    bit          u;
    #1;
    can = !m_full || rsp_ready[m_owner];
    if (req_valid == 2'b11) g = !m_last;
    else                    g = req_valid[1];
    er = can ? (req_valid & (g ? 2'b10 : 2'b01)) : 2'b00;
    ev = m_full ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", {30'd0, req_ready}, {30'd0, er});
    chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, ev});
    chk("rsp_out",   rsp_out, m_out);
    chk("rsp_zero",  {31'd0, rsp_zero}, {31'd0, m_zero});
    chk("rsp_less",  {31'd0, rsp_less}, {31'd0, m_less});
    op = g ? req1_op  : req0_op;
    a  = g ? req1_op1 : req0_op1;
    b  = g ? req1_op2 : req0_op2;
    u  = g ? req1_ucmp : req0_ucmp;
    @(posedge clk);
    if (er != 2'b00) begin
      m_out   = ref_out(op, a, b);
      m_zero  = (m_out == 32'd0);
      m_less  = u ? (a < b) : ($signed(a) < $signed(b));
      m_full  = 1;
      m_owner = g;
      m_last  = g;
    end else if (m_full && rsp_ready[m_owner]) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    set_req(0, ALU_ADD, 32'd0, 32'd0, 1'b0);
    set_req(1, ALU_ADD, 32'd0, 32'd0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_out",   rsp_out, 32'd0);
    chk("rst_flags",     {30'd0, rsp_zero, rsp_less}, 32'd0);
    rst_n = 1'b1;

    // Conflict after reset: requester 0 wins first, then alternation
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    set_req(0, ALU_SUB, 32'd3, 32'd3, 1'b0);
    set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    chk("conf_first_valid", {30'd0, rsp_valid}, 32'd1);
    chk("conf_first_out",   rsp_out, 32'd0);
    chk("conf_first_zero",  {31'd0, rsp_zero}, 32'd1);
    step();
    chk("conf_second_valid", {30'd0, rsp_valid}, 32'd2);
    chk("conf_second_out",   rsp_out, 32'd1);
    chk("conf_second_less",  {31'd0, rsp_less}, 32'd1);
    repeat (4) step();
    req_valid = 2'b00;
    step();

    // Single op
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    set_req(0, ALU_ADD, 32'd5, 32'd7, 1'b0);
    step();
    chk("single_valid", {30'd0, rsp_valid}, 32'd1);
    chk("single_out",   rsp_out, 32'd12);
    chk("single_zero",  {31'd0, rsp_zero}, 32'd0);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    step();

    // Back-pressure on a requester-1 result, then drain plus same-cycle accept
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    set_req(1, ALU_ADD, 32'd100, 32'd23, 1'b0);
    step();
    req_valid = 2'b01;
    set_req(0, ALU_XOR, 32'h0F0F_0F0F, 32'hFFFF_0000, 1'b0);
    repeat (5) step();
    chk("bp_held_out", rsp_out, 32'd123);
    rsp_ready = 2'b10;
    step();
    chk("bp_reload_valid", {30'd0, rsp_valid}, 32'd1);
    chk("bp_reload_out",   rsp_out, 32'hF0F0_0F0F);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    step();

    // Throughput: one result per cycle
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    for (int i = 0; i < 8; i++) begin
      set_req(0, ops[$urandom_range(0, 10)], rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
      step();
      chk("thru_valid", {30'd0, rsp_valid}, 32'd1);
    end

    // Flags and wrap-around
    set_req(0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step();
    chk("sltu_u_out",  rsp_out, 32'd0);
    chk("sltu_u_less", {31'd0, rsp_less}, 32'd0);
    set_req(0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    chk("sltu_s_less", {31'd0, rsp_less}, 32'd1);
    set_req(0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    chk("wrap_out",  rsp_out, 32'd0);
    chk("wrap_zero", {31'd0, rsp_zero}, 32'd1);
    req_valid = 2'b00;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      set_req(0, ops[$urandom_range(0, 10)], rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
      set_req(1, ops[$urandom_range(0, 10)], rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
      step();
    end

    // Reset while FULL
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    set_req(1, ALU_OR, 32'h1234_0000, 32'h0000_5678, 1'b0);
    step();
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
    model_reset();
`ifdef YSYX_25030081_ALU_ARB_PERF_EN
    chk("perf_grant0",   perf_grant0, 32'd0);
    chk("perf_grant1",   perf_grant1, 32'd0);
    chk("perf_conflict", perf_conflict, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    set_req(0, ALU_PASS2, 32'd0, 32'hCAFE_0000, 1'b0);
    set_req(1, ALU_PASS2, 32'd0, 32'hBEEF_0000, 1'b0);
    step();
    chk("midrst_winner_valid", {30'd0, rsp_valid}, 32'd1);
    chk("midrst_winner_out",   rsp_out, 32'hCAFE_0000);
    step();
    req_valid = 2'b00;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
